// File: rtl/bht_pkg.sv
// Shared types and defaults for the BHT update scheduler.
package bht_pkg;

    localparam int PCW_DEFAULT   = 32;
    localparam int BHT_UPD_PORTS = 2;

    typedef struct packed {
        logic [PCW_DEFAULT-1:0] pc;
        logic                   taken;
    } bht_upd_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } bht_fill_e;

endpackage

// File: rtl/bht_update_scheduler_if.sv
// Branch-unit update handshakes and predictor write port of the BHT update scheduler.
interface bht_update_scheduler_if
    import bht_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PCW   = PCW_DEFAULT
);
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic            i_upd0_valid;
    logic [PCW-1:0]  i_upd0_pc;
    logic            i_upd0_taken;
    logic            o_upd0_ready;
    logic            i_upd1_valid;
    logic [PCW-1:0]  i_upd1_pc;
    logic            i_upd1_taken;
    logic            o_upd1_ready;
    logic            i_hold;
    logic            o_bht_write_en;
    logic [PCW-1:0]  o_bht_write_pc;
    logic            o_bht_write_taken;
    logic [CNTW-1:0] o_count;
    logic            o_idle;

    modport master (
        output i_upd0_valid, i_upd0_pc, i_upd0_taken,
        output i_upd1_valid, i_upd1_pc, i_upd1_taken,
        output i_hold,
        input  o_upd0_ready, o_upd1_ready,
        input  o_bht_write_en, o_bht_write_pc, o_bht_write_taken,
        input  o_count, o_idle
    );

    modport slave (
        input  i_upd0_valid, i_upd0_pc, i_upd0_taken,
        input  i_upd1_valid, i_upd1_pc, i_upd1_taken,
        input  i_hold,
        output o_upd0_ready, o_upd1_ready,
        output o_bht_write_en, o_bht_write_pc, o_bht_write_taken,
        output o_count, o_idle
    );

endinterface

// File: rtl/bht_upd_fifo.sv
// Dual-write, single-read circular store of branch updates; the head entry is read combinationally.
module bht_upd_fifo
    import bht_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wr0_en,
    input  bht_upd_t wr0_data,
    input  logic     wr1_en,
    input  bht_upd_t wr1_data,
    input  logic     rd_en,
    output bht_upd_t rd_data
);
    localparam int AW = $clog2(DEPTH);

    bht_upd_t      mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] wptr_p1;
    logic [AW-1:0] rptr;
    logic          wr_a;
    logic          wr_b;
    bht_upd_t      data_a;

    // Slot A takes the older of the firing ports; slot B only carries port 1 when both fire.
    assign wptr_p1 = wptr + AW'(1);
    assign wr_a    = wr0_en | wr1_en;
    assign wr_b    = wr0_en & wr1_en;
    assign data_a  = wr0_en ? wr0_data : wr1_data;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_a) mem[wptr]    <= data_a;
        if (wr_b) mem[wptr_p1] <= wr1_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + AW'(wr_a) + AW'(wr_b);
            rptr <= rptr + AW'(rd_en);
        end
    end

endmodule

// File: rtl/bht_update_scheduler.sv
// Serialises resolved-branch outcomes from two branch units onto the single BHT write port.
//   state      | meaning
//   ST_EMPTY   | nothing pending, predictor write port idle
//   ST_PARTIAL | 1..DEPTH-1 updates pending
//   ST_FULL    | DEPTH updates pending, both ports stalled
module bht_update_scheduler
    import bht_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PCW   = PCW_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    bht_update_scheduler_if.slave bus
);
    localparam int              CNTW     = $clog2(DEPTH) + 1;
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_RDY0 = CNTW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_RDY1 = CNTW'(DEPTH - 2);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PCW != $bits(bht_upd_t) - 1) begin : g_bad_cfg
            $error("bht_update_scheduler: DEPTH must be a power of two >= 2 and PCW must match bht_pkg");
        end
    endgenerate

    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_next;
    bht_fill_e       state;
    logic            rdy0;
    logic            rdy1;
    logic            fire0;
    logic            fire1;
    logic            deq;
    bht_upd_t        wr0_data;
    bht_upd_t        wr1_data;
    bht_upd_t        head;

    // Readiness looks only at the registered count, so a same-cycle drain never frees a slot.
    assign rdy0       = (count <= CNT_RDY0);
    assign rdy1       = (count <= CNT_RDY1);
    assign fire0      = bus.i_upd0_valid & rdy0;
    assign fire1      = bus.i_upd1_valid & rdy1;
    assign deq        = (state != ST_EMPTY) & ~bus.i_hold;
    assign count_next = count + CNTW'(fire0) + CNTW'(fire1) - CNTW'(deq);

    assign wr0_data = '{pc: bus.i_upd0_pc, taken: bus.i_upd0_taken};
    assign wr1_data = '{pc: bus.i_upd1_pc, taken: bus.i_upd1_taken};

    bht_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (fire0),
        .wr0_data (wr0_data),
        .wr1_en   (fire1),
        .wr1_data (wr1_data),
        .rd_en    (deq),
        .rd_data  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            state <= ST_EMPTY;
        end else begin
            count <= count_next;
            if (count_next == '0)
                state <= ST_EMPTY;
            else if (count_next == CNT_FULL)
                state <= ST_FULL;
            else
                state <= ST_PARTIAL;
        end
    end

    assign bus.o_upd0_ready      = rdy0;
    assign bus.o_upd1_ready      = rdy1;
    assign bus.o_bht_write_en    = deq;
    assign bus.o_bht_write_pc    = head.pc;
    assign bus.o_bht_write_taken = head.taken;
    assign bus.o_count           = count;
    assign bus.o_idle            = (state == ST_EMPTY);

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Directed bench for bht_update_scheduler: queue-based reference model plus hand-computed checkpoints.
module tb_bht_update_scheduler;
    import bht_pkg::*;

    localparam int DEPTH = 8;
    localparam int PCW   = PCW_DEFAULT;
    localparam int TMO   = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    bht_update_scheduler_if #(.DEPTH(DEPTH), .PCW(PCW)) bus ();

    bht_update_scheduler #(.DEPTH(DEPTH), .PCW(PCW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending updates in acceptance order, plus the log of writes issued.
    bht_upd_t q[$];
    bht_upd_t wlog[$];
    int       acc0 = 0;
    int       acc1 = 0;
    int       m_sz;
    bit       m_f0;
    bit       m_f1;
    bht_upd_t m_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            m_sz = q.size();
            m_f0 = bus.i_upd0_valid && (m_sz < DEPTH);
            m_f1 = bus.i_upd1_valid && (m_sz < DEPTH - 1);
            if (m_sz > 0 && !bus.i_hold) wlog.push_back(q.pop_front());
            if (m_f0) begin
                m_e.pc = bus.i_upd0_pc; m_e.taken = bus.i_upd0_taken;
                q.push_back(m_e); acc0++;
            end
            if (m_f1) begin
                m_e.pc = bus.i_upd1_pc; m_e.taken = bus.i_upd1_taken;
                q.push_back(m_e); acc1++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("count", bus.o_count, q.size());
            check("idle", bus.o_idle, q.size() == 0);
            check("ready0", bus.o_upd0_ready, q.size() < DEPTH);
            check("ready1", bus.o_upd1_ready, q.size() < DEPTH - 1);
            check("write_en", bus.o_bht_write_en, (q.size() != 0) && !bus.i_hold);
            if (q.size() != 0) begin
                check("write_pc", bus.o_bht_write_pc, q[0].pc);
                check("write_taken", bus.o_bht_write_taken, q[0].taken);
            end
        end
    end

    task automatic req(input bit v0, input logic [PCW-1:0] pc0, input bit t0,
                       input bit v1, input logic [PCW-1:0] pc1, input bit t1);
        bus.i_upd0_valid = v0; bus.i_upd0_pc = pc0; bus.i_upd0_taken = t0;
        bus.i_upd1_valid = v1; bus.i_upd1_pc = pc1; bus.i_upd1_taken = t1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds each raised valid until the model records that port as accepted.
    task automatic wait_acc(input string name);
        int a0 = acc0;
        int a1 = acc1;
        int n  = 0;
        while ((bus.i_upd0_valid || bus.i_upd1_valid) && n < TMO) begin
            @(posedge clk); #1; n++;
            if (acc0 != a0) bus.i_upd0_valid = 1'b0;
            if (acc1 != a1) bus.i_upd1_valid = 1'b0;
        end
        if (bus.i_upd0_valid || bus.i_upd1_valid) begin
            checks++; errors++;
            $display("FAIL %s: request still pending after %0d cycles", name, TMO);
            bus.i_upd0_valid = 1'b0; bus.i_upd1_valid = 1'b0;
        end
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (q.size() != 0 && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s: %0d updates still pending after %0d cycles", name, q.size(), TMO);
        end
    endtask

    initial begin
        int w;
        bus.i_hold = 1'b0;
        req(0, '0, 0, 0, '0, 0);
        #1 rst = 1'b1;
        #1;
        check("rst_count", bus.o_count, 0);
        check("rst_idle", bus.o_idle, 1);
        check("rst_ready0", bus.o_upd0_ready, 1);
        check("rst_ready1", bus.o_upd1_ready, 1);
        check("rst_write_en", bus.o_bht_write_en, 0);
        @(negedge clk); rst = 1'b0;
        tick(1);

        // Single update on port 0
        req(1, 32'h1234, 1, 0, '0, 0);
        tick(1);
        bus.i_upd0_valid = 1'b0;
        @(negedge clk);
        check("single_en", bus.o_bht_write_en, 1);
        check("single_pc", bus.o_bht_write_pc, 32'h1234);
        check("single_taken", bus.o_bht_write_taken, 1);
        check("single_count1", bus.o_count, 1);
        @(negedge clk);
        check("single_count0", bus.o_count, 0);
        check("single_idle", bus.o_idle, 1);
        tick(1);

        // Dual enqueue keeps port 0 ahead of port 1
        w = wlog.size();
        req(1, 32'h100, 1, 1, 32'h200, 0);
        wait_acc("dual_acc");
        @(negedge clk);
        check("dual_pc0", bus.o_bht_write_pc, 32'h100);
        check("dual_taken0", bus.o_bht_write_taken, 1);
        @(negedge clk);
        check("dual_pc1", bus.o_bht_write_pc, 32'h200);
        check("dual_taken1", bus.o_bht_write_taken, 0);
        tick(2);
        check("dual_log_n", wlog.size() - w, 2);
        check("dual_log_pc0", wlog[w].pc, 32'h100);
        check("dual_log_pc1", wlog[w+1].pc, 32'h200);

        // Fill under hold, stalled fifth request, then in-order drain
        bus.i_hold = 1'b1;
        w = wlog.size();
        for (int k = 0; k < 4; k++) begin
            req(1, 32'h1000 + 32'h10 * (2 * k), 0, 1, 32'h1000 + 32'h10 * (2 * k + 1), 1);
            wait_acc("fill_acc");
        end
        @(negedge clk);
        check("full_count", bus.o_count, 8);
        check("full_ready0", bus.o_upd0_ready, 0);
        check("full_ready1", bus.o_upd1_ready, 0);
        check("full_hold_en", bus.o_bht_write_en, 0);
        tick(1);
        req(1, 32'h2000, 0, 1, 32'h2010, 1);
        tick(3);
        @(negedge clk);
        check("stall_count", bus.o_count, 8);
        check("stall_no_write", wlog.size() - w, 0);
        tick(1);
        bus.i_hold = 1'b0;
        wait_acc("fifth_acc");
        wait_empty("fill_drain");
        check("fill_log_n", wlog.size() - w, 10);
        for (int i = 0; i < 10; i++) begin
            check("fill_log_pc", wlog[w+i].pc, (i < 8) ? 32'h1000 + 32'h10 * i : 32'h2000 + 32'h10 * (i - 8));
            check("fill_log_taken", wlog[w+i].taken, i % 2);
        end

        // Count = DEPTH-1 with both ports valid: only port 0 fits
        bus.i_hold = 1'b1;
        w = wlog.size();
        for (int k = 0; k < 3; k++) begin
            req(1, 32'h3000 + 32'h10 * (2 * k), 0, 1, 32'h3000 + 32'h10 * (2 * k + 1), 1);
            wait_acc("b7_fill");
        end
        req(1, 32'h3060, 0, 0, '0, 0);
        wait_acc("b7_single");
        req(1, 32'h3070, 1, 1, 32'h3080, 0);
        @(negedge clk);
        check("b7_count", bus.o_count, 7);
        check("b7_ready0", bus.o_upd0_ready, 1);
        check("b7_ready1", bus.o_upd1_ready, 0);
        tick(1);
        bus.i_upd0_valid = 1'b0;
        @(negedge clk);
        check("b7_count8", bus.o_count, 8);
        check("b7_ready1_full", bus.o_upd1_ready, 0);
        tick(1);
        bus.i_hold = 1'b0;
        wait_acc("b7_port1");
        wait_empty("b7_drain");
        check("b7_log_n", wlog.size() - w, 9);
        for (int i = 0; i < 9; i++) begin
            check("b7_log_pc", wlog[w+i].pc, 32'h3000 + 32'h10 * i);
            check("b7_log_taken", wlog[w+i].taken, i % 2);
        end

        // Wrap-around with random gaps
        w = wlog.size();
        for (int k = 1; k <= 20; k++) begin
            req(1, 32'h40 * k, k[0], 0, '0, 0);
            wait_acc("wrap_acc");
            tick($urandom_range(0, 2));
        end
        wait_empty("wrap_drain");
        check("wrap_log_n", wlog.size() - w, 20);
        for (int i = 0; i < 20; i++) begin
            check("wrap_log_pc", wlog[w+i].pc, 32'h40 * (i + 1));
            check("wrap_log_taken", wlog[w+i].taken, (i + 1) % 2);
        end

        // Reset in the middle of a drain
        bus.i_hold = 1'b1;
        req(1, 32'h4000, 0, 1, 32'h4010, 1);
        wait_acc("rstm_fill0");
        req(1, 32'h4020, 0, 1, 32'h4030, 1);
        wait_acc("rstm_fill1");
        req(1, 32'h4040, 0, 0, '0, 0);
        wait_acc("rstm_fill2");
        @(negedge clk);
        check("rstm_count5", bus.o_count, 5);
        tick(1);
        bus.i_hold = 1'b0;
        w = wlog.size();
        #2 rst = 1'b1;
        #1;
        check("rstm_en", bus.o_bht_write_en, 0);
        check("rstm_count", bus.o_count, 0);
        check("rstm_idle", bus.o_idle, 1);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstm_no_stale", bus.o_bht_write_en, 0);
        end
        check("rstm_log_n", wlog.size() - w, 0);
        tick(1);
        req(1, 32'h5555, 1, 0, '0, 0);
        tick(1);
        bus.i_upd0_valid = 1'b0;
        @(negedge clk);
        check("post_rst_en", bus.o_bht_write_en, 1);
        check("post_rst_pc", bus.o_bht_write_pc, 32'h5555);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
